seg_display_monitor: RTL and testbench
======================================

# seg_display_monitor

Receive-side checker for the countdown's two-digit seven-segment display. Samples the active-low segment buses driven to the tube, filters glitches with a stability window, and decodes the patterns back to BCD. Checks that each accepted value follows the countdown sequence (decrement by one, or reload) and flags illegal segment patterns. Sits beside the display driver in the countdown build and in benches, as the inverse of the BCD-to-segment encoder.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range ≥2.
- RELOAD_VALUE, 15: decimal value that may follow any value without a sequence error.
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low.
- bs1  in  7  tens-digit segments, active-low, bit 0 = segment a.
- bs0  in  7  units-digit segments, same encoding.
- err_clr  in  1  synchronous clear of sticky error flags and bad_cnt.
- time_h  out  4  last accepted tens digit, BCD.
- time_l  out  4  last accepted units digit, BCD.
- valid  out  1  at least one value accepted since reset.
- new_value  out  1  one-cycle pulse when time_h/time_l update.
- done  out  1  last accepted value is 00.
- pattern_err  out  1  sticky: a stable, non-blank, undecodable pattern was seen.
- seq_err  out  1  sticky: an accepted value broke the countdown sequence.
- bad_cnt  out  8  saturating count of pattern_err events.

## Operation
- Digit encoding: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Any other value is invalid. 7'h7F is blank.
- Input stage: s1/s0 register bs1/bs0 every cycle; reset value 7'h7F.
- Candidate stage: cand1/cand0 and counter cnt, sized $clog2(STABLE_CYCLES+1).
  - If {s1,s0} ≠ {cand1,cand0}: load the candidate and set cnt=0.
  - Otherwise: increment cnt, saturating at STABLE_CYCLES.
- Settle event: a single cycle in which cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. The candidate is then handled as follows:
  - Both digits blank: ignored. No update, no error.
  - Either digit invalid, or exactly one digit blank: pattern_err set, bad_cnt incremented (saturates at 255), outputs unchanged.
  - Both digits valid and the pair equals the current accepted value while valid=1: no action.
  - Otherwise: accept. Update time_h/time_l, pulse new_value, set valid, set done = (value==00), and run the sequence check.
- Sequence check uses V = 10·H+L. It is skipped on the first accept after reset.
  - No error when V == previous-1, or when V == RELOAD_VALUE.
  - Any other V sets seq_err; this includes previous==0 with V≠RELOAD_VALUE. The value is still accepted.
- err_clr clears pattern_err, seq_err and bad_cnt. If a new error occurs in the same cycle, the flag ends up set and bad_cnt ends at 1.
- State machine: IDLE (valid=0) → TRACK on the first accept. TRACK persists until reset.

## Timing
- Inputs held stable from before edge k: s-regs load at edge k, candidate loads at k+1, settle event at k+STABLE_CYCLES, outputs and new_value register at edge k+STABLE_CYCLES+1. This is edge k+5 with the default.
- A change lasting ≤ STABLE_CYCLES samples never updates the outputs.
- Reset, asynchronous and at any time, including mid-settle: all outputs go to 0 and s/cand go to 7'h7F with cnt=0. After release a full window is required again.
- All outputs are registered. There are no combinational paths from the inputs to the outputs.

## Structure
- Shared package seg7_pkg holds:
  - SEG_DIGIT[0:9] pattern constants and SEG_BLANK = 7'h7F.
  - The invalid-code constant 4'hF.
- Sub-module seg7_digit_decode: combinational pattern → {valid, bcd}, instantiated twice.
- The top holds the input registers, the stability counter, the two-state FSM, the sequence comparator and the error logic.

## Test plan
- Reset, then hold bs1=7'h79 and bs0=7'h12 → at edge k+5: time_h=1, time_l=5, valid=1, one new_value pulse, no errors.
- Count down from 15 to 00, holding each value 8 cycles → 15 new_value pulses after the first, seq_err=0, done=1 on 00.
- At value 12, drive bs0=7'h30 for 3 cycles, then back to 7'h24 → no new_value, outputs remain 1/2.
- Hold bs0=7'h7E for 6 cycles → pattern_err=1, bad_cnt=1, time unchanged; then pulse err_clr → both return to 0.
- Sequence cases:
  - 12 then 10 → seq_err=1 with time=10.
  - After clearing, 00 then 15 → no error.
  - 00 then 07 → seq_err=1.
- Assert reset after 2 stable cycles of a new pattern → outputs 0 immediately. After release, hold the pattern → acceptance exactly STABLE_CYCLES+1 edges after the first post-release sample edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the countdown display monitor.
// Patterns are active-low, with bit 0 driving segment a.
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        ST_IDLE,
        ST_TRACK
    } mon_state_e;

    function automatic logic [6:0] bcd_pair_value(input logic [3:0] h, input logic [3:0] l);
        return 7'(h) * 7'd10 + 7'(l);
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational inverse of the BCD-to-segment encoder for one digit.
// Blank and unknown patterns both report valid_o=0 with BCD_INVALID.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        valid_o = 1'b0;
        bcd_o   = BCD_INVALID;
        for (int i = 0; i < 10; i++) begin
            if (seg_i == SEG_DIGIT[i]) begin
                valid_o = 1'b1;
                bcd_o   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_display_monitor.sv
// Receive-side checker for the two-digit countdown display: glitch filter,
// segment decode, countdown sequence check and sticky error reporting.
//   state    | meaning
//   ST_IDLE  | nothing accepted since reset, valid=0
//   ST_TRACK | a value has been accepted, sequence check active
module seg_display_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int RELOAD_VALUE  = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] bs1,
    input  logic [6:0] bs0,
    input  logic       err_clr,
    output logic [3:0] time_h,
    output logic [3:0] time_l,
    output logic       valid,
    output logic       new_value,
    output logic       done,
    output logic       pattern_err,
    output logic       seq_err,
    output logic [7:0] bad_cnt
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       RELOAD_V = 7'(RELOAD_VALUE);

    mon_state_e       state_q, state_d;
    logic [6:0]       s1_q, s0_q, cand1_q, cand1_d, cand0_q, cand0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       time_h_q, time_h_d, time_l_q, time_l_d;
    logic             new_value_q, new_value_d, done_q, done_d;
    logic             pattern_err_q, pattern_err_d, seq_err_q, seq_err_d;
    logic [7:0]       bad_cnt_q, bad_cnt_d;

    logic       dv1, dv0, settle, pat_hit, seq_hit;
    logic [3:0] bcd1, bcd0;
    logic [6:0] val_new, val_prev;

    seg7_digit_decode u_dec1 (.seg_i(cand1_q), .valid_o(dv1), .bcd_o(bcd1));
    seg7_digit_decode u_dec0 (.seg_i(cand0_q), .valid_o(dv0), .bcd_o(bcd0));

    assign val_new  = bcd_pair_value(bcd1, bcd0);
    assign val_prev = bcd_pair_value(time_h_q, time_l_q);
    assign settle   = ({s1_q, s0_q} == {cand1_q, cand0_q}) && (cnt_q == CNT_LAST);

    always_comb begin
        cand1_d     = cand1_q;
        cand0_d     = cand0_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        time_h_d    = time_h_q;
        time_l_d    = time_l_q;
        new_value_d = 1'b0;
        done_d      = done_q;
        pat_hit     = 1'b0;
        seq_hit     = 1'b0;

        if ({s1_q, s0_q} != {cand1_q, cand0_q}) begin
            cand1_d = s1_q;
            cand0_d = s0_q;
            cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (settle) begin
            if (cand1_q == SEG_BLANK && cand0_q == SEG_BLANK) begin
                pat_hit = 1'b0;
            end else if (!dv1 || !dv0) begin
                pat_hit = 1'b1;
            end else if (!(state_q == ST_TRACK && bcd1 == time_h_q && bcd0 == time_l_q)) begin
                time_h_d    = bcd1;
                time_l_d    = bcd0;
                new_value_d = 1'b1;
                done_d      = (val_new == 7'd0);
                state_d     = ST_TRACK;
                // Reaching 00 leaves previous-1 unreachable, so only a reload passes.
                seq_hit     = (state_q == ST_TRACK) &&
                              !((val_new + 7'd1 == val_prev) || (val_new == RELOAD_V));
            end
        end

        pattern_err_d = (pattern_err_q && !err_clr) || pat_hit;
        seq_err_d     = (seq_err_q && !err_clr) || seq_hit;
        bad_cnt_d     = err_clr ? 8'd0 : bad_cnt_q;
        if (pat_hit && bad_cnt_d != 8'hFF) begin
            bad_cnt_d = bad_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q          <= SEG_BLANK;
            s0_q          <= SEG_BLANK;
            cand1_q       <= SEG_BLANK;
            cand0_q       <= SEG_BLANK;
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            time_h_q      <= 4'd0;
            time_l_q      <= 4'd0;
            new_value_q   <= 1'b0;
            done_q        <= 1'b0;
            pattern_err_q <= 1'b0;
            seq_err_q     <= 1'b0;
            bad_cnt_q     <= 8'd0;
        end else begin
            s1_q          <= bs1;
            s0_q          <= bs0;
            cand1_q       <= cand1_d;
            cand0_q       <= cand0_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            time_h_q      <= time_h_d;
            time_l_q      <= time_l_d;
            new_value_q   <= new_value_d;
            done_q        <= done_d;
            pattern_err_q <= pattern_err_d;
            seq_err_q     <= seq_err_d;
            bad_cnt_q     <= bad_cnt_d;
        end
    end

    assign time_h      = time_h_q;
    assign time_l      = time_l_q;
    assign valid       = (state_q == ST_TRACK);
    assign new_value   = new_value_q;
    assign done        = done_q;
    assign pattern_err = pattern_err_q;
    assign seq_err     = seq_err_q;
    assign bad_cnt     = bad_cnt_q;

endmodule

// File: tb/tb_seg_display_monitor.sv
// Scenario bench for seg_display_monitor: accepted values are queued when
// driven and matched against every new_value pulse by a negedge monitor.
module tb_seg_display_monitor;

    localparam logic [6:0] SEG [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] bs1, bs0;
    logic       err_clr;
    logic [3:0] time_h, time_l;
    logic       valid, new_value, done, pattern_err, seq_err;
    logic [7:0] bad_cnt;

    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;
    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    seg_display_monitor #(.STABLE_CYCLES(4), .RELOAD_VALUE(15)) dut (
        .clock(clock), .reset(reset), .bs1(bs1), .bs0(bs0), .err_clr(err_clr),
        .time_h(time_h), .time_l(time_l), .valid(valid), .new_value(new_value),
        .done(done), .pattern_err(pattern_err), .seq_err(seq_err), .bad_cnt(bad_cnt)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset === 1'b1 && new_value === 1'b1) begin
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%0d%0d expected=none", time_h, time_l);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({time_h, time_l} !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_value got=%0d%0d expected=%0d%0d",
                             time_h, time_l, sb_exp[7:4], sb_exp[3:0]);
                end
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_val(input int v);
        bs1 = SEG[v / 10];
        bs0 = SEG[v % 10];
    endtask

    task automatic push_val(input int v);
        exp_q.push_back({4'(v / 10), 4'(v % 10)});
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; err_clr = 1'b0; bs1 = 7'h7F; bs0 = 7'h7F;
        wait_neg(3);
        total++;
        if ({time_h, time_l, valid, new_value, done, pattern_err, seq_err, bad_cnt} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {time_h, time_l, valid, new_value, done, pattern_err, seq_err, bad_cnt});
        end
    endtask

    task automatic test_first_accept();
        reset = 1'b1;
        wait_neg(2);
        set_val(15); push_val(15);
        wait_neg(5);
        total++;
        if (valid !== 1'b0 || new_value !== 1'b0) begin
            bad++; $display("FAIL first_early valid=%b new_value=%b required=0/0", valid, new_value);
        end
        wait_neg(1);
        total++;
        if (new_value !== 1'b1 || valid !== 1'b1 || time_h !== 4'd1 || time_l !== 4'd5) begin
            bad++; $display("FAIL first_accept nv=%b valid=%b time=%0d%0d required=1/1/15",
                            new_value, valid, time_h, time_l);
        end
        total++;
        if (pattern_err !== 1'b0 || seq_err !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL first_flags perr=%b serr=%b done=%b required=0", pattern_err, seq_err, done);
        end
        wait_neg(1);
        total++;
        if (new_value !== 1'b0) begin
            bad++; $display("FAIL first_single_pulse new_value=%b required=0", new_value);
        end
        wait_neg(6);
    endtask

    task automatic test_countdown();
        int p0 = pulses;
        for (int v = 14; v >= 0; v--) begin
            set_val(v); push_val(v);
            wait_neg(8);
            if (v == 5) begin
                total++;
                if (done !== 1'b0) begin
                    bad++; $display("FAIL countdown_done_mid done=%b required=0", done);
                end
            end
        end
        total++;
        if (pulses - p0 != 15) begin
            bad++; $display("FAIL countdown_pulses got=%0d required=15", pulses - p0);
        end
        total++;
        if (seq_err !== 1'b0 || done !== 1'b1 || time_h !== 4'd0 || time_l !== 4'd0) begin
            bad++; $display("FAIL countdown_end serr=%b done=%b time=%0d%0d required=0/1/00",
                            seq_err, done, time_h, time_l);
        end
        for (int v = 15; v >= 12; v--) begin
            set_val(v); push_val(v);
            wait_neg(8);
        end
        total++;
        if (seq_err !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reload_path serr=%b done=%b required=0/0", seq_err, done);
        end
    endtask

    task automatic test_glitch();
        int p0 = pulses;
        bs0 = SEG[3]; wait_neg(3); bs0 = SEG[2]; wait_neg(8);
        bs0 = SEG[3]; wait_neg(4); bs0 = SEG[2]; wait_neg(8);
        total++;
        if (pulses != p0 || time_h !== 4'd1 || time_l !== 4'd2) begin
            bad++; $display("FAIL glitch_filter pulses=%0d time=%0d%0d required=%0d/12",
                            pulses, time_h, time_l, p0);
        end
    endtask

    task automatic test_pattern_err();
        int p0 = pulses;
        bs0 = 7'h7E; wait_neg(6); bs0 = SEG[2]; wait_neg(8);
        total++;
        if (pattern_err !== 1'b1 || bad_cnt !== 8'd1 || time_h !== 4'd1 || time_l !== 4'd2 || pulses != p0) begin
            bad++; $display("FAIL pattern_err perr=%b bad_cnt=%0d time=%0d%0d required=1/1/12",
                            pattern_err, bad_cnt, time_h, time_l);
        end
        err_clr = 1'b1; wait_neg(1);
        total++;
        if (pattern_err !== 1'b0 || bad_cnt !== 8'd0) begin
            bad++; $display("FAIL err_clr perr=%b bad_cnt=%0d required=0/0", pattern_err, bad_cnt);
        end
        err_clr = 1'b0;
        bs1 = 7'h7F; bs0 = 7'h7F; wait_neg(8);
        total++;
        if (pattern_err !== 1'b0 || pulses != p0 || time_l !== 4'd2) begin
            bad++; $display("FAIL blank_ignored perr=%b pulses=%0d required=0/%0d", pattern_err, pulses, p0);
        end
        bs0 = SEG[2]; wait_neg(8);
        total++;
        if (pattern_err !== 1'b1 || bad_cnt !== 8'd1) begin
            bad++; $display("FAIL half_blank perr=%b bad_cnt=%0d required=1/1", pattern_err, bad_cnt);
        end
        bs1 = SEG[1]; wait_neg(8);
        total++;
        if (pulses != p0) begin
            bad++; $display("FAIL same_value_reaccept pulses=%0d required=%0d", pulses, p0);
        end
        pulse_clr();
    endtask

    task automatic test_sequence();
        set_val(10); push_val(10); wait_neg(8);
        total++;
        if (seq_err !== 1'b1 || time_h !== 4'd1 || time_l !== 4'd0) begin
            bad++; $display("FAIL seq_skip serr=%b time=%0d%0d required=1/10", seq_err, time_h, time_l);
        end
        set_val(0); push_val(0); wait_neg(8);
        pulse_clr(); wait_neg(1);
        total++;
        if (seq_err !== 1'b0) begin
            bad++; $display("FAIL seq_clear serr=%b required=0", seq_err);
        end
        set_val(15); push_val(15); wait_neg(8);
        total++;
        if (seq_err !== 1'b0) begin
            bad++; $display("FAIL seq_reload_from_zero serr=%b required=0", seq_err);
        end
        set_val(0); push_val(0); wait_neg(8);
        pulse_clr();
        set_val(7); push_val(7); wait_neg(8);
        total++;
        if (seq_err !== 1'b1 || time_l !== 4'd7) begin
            bad++; $display("FAIL seq_zero_to_7 serr=%b time_l=%0d required=1/7", seq_err, time_l);
        end
        pulse_clr();
    endtask

    task automatic test_clr_collide();
        bs0 = 7'h7E; wait_neg(8);
        total++;
        if (bad_cnt !== 8'd1) begin
            bad++; $display("FAIL collide_setup bad_cnt=%0d required=1", bad_cnt);
        end
        bs0 = SEG[7]; wait_neg(8);
        bs0 = 7'h7E;
        wait_neg(5);
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
        total++;
        if (bad_cnt !== 8'd1 || pattern_err !== 1'b1) begin
            bad++; $display("FAIL clr_same_cycle bad_cnt=%0d perr=%b required=1/1", bad_cnt, pattern_err);
        end
        bs0 = SEG[7]; wait_neg(8);
    endtask

    task automatic test_reset_mid();
        set_val(15);
        wait_neg(2);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({time_h, time_l, valid, new_value, done, pattern_err, seq_err, bad_cnt} !== 23'd0) begin
            bad++; $display("FAIL reset_mid got=%h required=0",
                            {time_h, time_l, valid, new_value, done, pattern_err, seq_err, bad_cnt});
        end
        @(negedge clock);
        reset = 1'b1;
        push_val(15);
        wait_neg(5);
        total++;
        if (valid !== 1'b0 || new_value !== 1'b0) begin
            bad++; $display("FAIL reset_early valid=%b nv=%b required=0/0", valid, new_value);
        end
        wait_neg(1);
        total++;
        if (new_value !== 1'b1 || valid !== 1'b1 || time_h !== 4'd1 || time_l !== 4'd5 || seq_err !== 1'b0) begin
            bad++; $display("FAIL reset_reaccept nv=%b valid=%b time=%0d%0d serr=%b required=1/1/15/0",
                            new_value, valid, time_h, time_l, seq_err);
        end
        wait_neg(4);
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_countdown();
        test_glitch();
        test_pattern_err();
        test_sequence();
        test_clr_collide();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
